// File: rtl/cgra_fifo_pkg.sv
// Shared definitions for the CGRA dataflow FIFO and its write-side arbiter:
// arbiter state encoding, a clog2 helper and the common width/depth defaults.
package cgra_fifo_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) is 0, so callers needing a 1-bit minimum clamp it.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int FIFO_DEPTH         = 16;
  localparam int FIFO_ADDR_W        = clog2(FIFO_DEPTH);

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first set request at or after ptr,
// wrapping from n-1 back to 0. Purely combinational.
module rr_pick
  import cgra_fifo_pkg::*;
#(
  parameter  int n = 4,
  localparam int W = (clog2(n) > 1) ? clog2(n) : 1
) (
  input  logic [n-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < n; k++) begin
      j = (int'(ptr) + k) % n;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between numInputs producers,
// with bounded bursts per grant and zero-bubble hand-over between grants.
module fifo_rr_arbiter
  import cgra_fifo_pkg::*;
#(
  parameter  int dataWidth = DATA_WIDTH_DEFAULT,
  parameter  int numInputs = 4,
  parameter  int maxBurst  = 4,
  localparam int IdW       = (clog2(numInputs) > 1) ? clog2(numInputs) : 1,
  localparam int BurstW    = clog2(maxBurst + 1)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [numInputs*dataWidth-1:0] inData,
  input  logic [numInputs-1:0]           inValid,
  output logic [numInputs-1:0]           inReady,
  output logic [dataWidth-1:0]           outData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [IdW-1:0]                 grantId,
  output logic                           busy,
  output logic [31:0]                    xferCount
);

  arb_state_e        state_q, state_d;
  logic [IdW-1:0]    grant_id_q, grant_id_d;
  logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
  logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]       xfer_count_q, xfer_count_d;

  logic           in_grant;
  logic           gnt_valid;
  logic           xfer;
  logic           burst_last;
  logic           release_grant;
  logic [IdW-1:0] next_ptr;
  logic [IdW-1:0] pick_ptr;
  logic           pick_found;
  logic [IdW-1:0] pick_idx;

  // Handshake: a word moves on a cycle where valid and ready are both high at
  // the rising edge; valid never depends on ready, ready may depend on state.
  assign in_grant      = (state_q == ARB_GRANT);
  assign gnt_valid     = inValid[grant_id_q];
  assign xfer          = in_grant && gnt_valid && outReady && !reset;
  assign burst_last    = (burst_cnt_q == BurstW'(maxBurst - 1));
  assign release_grant = in_grant && (!gnt_valid || (xfer && burst_last));
  assign next_ptr      = (int'(grant_id_q) == numInputs - 1) ? '0
                                                             : grant_id_q + IdW'(1);

  // One picker serves both the IDLE pick and the release re-pick.
  assign pick_ptr = in_grant ? next_ptr : rr_ptr_q;

  rr_pick #(
    .n(numInputs)
  ) u_pick (
    .req  (inValid),
    .ptr  (pick_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    burst_cnt_d  = burst_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    xfer_count_d = xfer_count_q + 32'(xfer);
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d     = ARB_GRANT;
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BurstW'(1);
        end
        if (release_grant) begin
          rr_ptr_d    = next_ptr;
          burst_cnt_d = '0;
          if (pick_found) begin
            grant_id_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      burst_cnt_q  <= '0;
      rr_ptr_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      burst_cnt_q  <= burst_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  always_comb begin
    inReady  = '0;
    outData  = '0;
    outValid = 1'b0;
    if (in_grant) begin
      outData             = inData[int'(grant_id_q)*dataWidth +: dataWidth];
      outValid            = gnt_valid && !reset;
      inReady[grant_id_q] = outReady && !reset;
    end
  end

  assign grantId   = grant_id_q;
  assign busy      = in_grant;
  assign xferCount = xfer_count_q;

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin write-side arbiter that shares one valid/ready FIFO input port (the CGRA's dataflow FIFO) between `numInputs` producer streams. It grants one producer at a time, holds the grant for a bounded burst, then rotates fairly. Data passes combinationally from the granted producer to the FIFO, so the arbiter adds no storage. It sits between processing-element outputs and a shared FIFO's `din`/`dinValid`/`dinReady` port.

## Interface
- `dataWidth`, 32: payload width.
- `numInputs`, 4: number of producer streams, ≥2.
- `maxBurst`, 4: maximum transfers per grant, ≥1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `inData`  in  numInputs*dataWidth: producer payloads; port i occupies bits [i*dataWidth +: dataWidth].
- `inValid`  in  numInputs: producer valid, one bit per port.
- `inReady`  out  numInputs: per-port ready; only the granted bit can be 1.
- `outData`  out  dataWidth: to FIFO `din`.
- `outValid`  out  1: to FIFO `dinValid`.
- `outReady`  in  1: from FIFO `dinReady`.
- `grantId`  out  max(1,clog2(numInputs)): index of the current or last grant.
- `busy`  out  1: high while in GRANT.
- `xferCount`  out  32: total accepted transfers; wraps modulo 2^32.

## Operation
- States are IDLE and GRANT. Registers: `state`, `grantId`, `burstCnt` (clog2(maxBurst+1) bits), `rrPtr`, `xferCount`.
- **Transfer:** in GRANT, a transfer occurs when `inValid[grantId] & outReady`. On each transfer `burstCnt` increments by 1 and `xferCount` increments by 1.
- **Datapath:** in GRANT, `outData = inData[grantId]`, `outValid = inValid[grantId]`, and `inReady[grantId] = outReady`. In IDLE, `outData = 0`, `outValid = 0`, and all `inReady` are 0.
- **Pick:** select the first index j with `inValid[j]` = 1, scanning from `rrPtr` upward and wrapping at numInputs-1 back to 0.
- **IDLE:** if any `inValid` is set, go to GRANT with `grantId` = pick and `burstCnt` = 0. Otherwise stay in IDLE.
- **Release in GRANT** happens when either condition holds:
  - a transfer occurs with `burstCnt == maxBurst-1`, or
  - `inValid[grantId]` = 0 (no transfer that cycle).
- **On release:** set `rrPtr = (grantId+1) mod numInputs` and re-pick in the same cycle, with the releasing port's own valid still considered.
  - If the pick succeeds, stay in GRANT with the new `grantId` and `burstCnt` = 0. There is no bubble.
  - Otherwise go to IDLE.
- A port re-wins after its own release only if no other port is valid.
- **Back-pressure:** if `outReady` = 0 in GRANT, the grant is held and `burstCnt` is unchanged. The burst limit counts transfers, not cycles.
- **maxBurst = 1:** every transfer rotates the grant.
- **Producer protocol:** a producer drops `inValid` only after a handshake. If it drops valid, it loses the grant.

## Timing
- **Reset values:**
  - `state` = IDLE, `grantId` = 0, `rrPtr` = 0, `burstCnt` = 0, `xferCount` = 0.
  - `outValid` = 0, `outData` = 0, `inReady` = 0, `busy` = 0.
- `inReady` and `outValid` are gated by `~reset`, so no transfer is accepted in a reset cycle, including a reset asserted mid-burst. After reset the next state is IDLE.
- **Grant latency:** 1 cycle from the first `inValid` in IDLE to `busy`/`outValid`. Back-to-back grants between ports have 0 idle cycles.
- **Throughput:** 1 word per cycle while the granted port is valid and `outReady` = 1.
- `outData`, `outValid` and `inReady` are combinational from registered state and the current inputs. There is no combinational path from `outReady` to `outValid`.

## Structure
- The shared package `cgra_fifo_pkg` holds:
  - state encoding constants `ARB_IDLE`/`ARB_GRANT`;
  - a `clog2` function;
  - default `dataWidth` and the FIFO depth constants, shared with the FIFO.
- Sub-module `rr_pick`: purely combinational rotating-priority picker, with parameter `n`, inputs `req[n]` and `ptr`, and outputs `found` and `idx`. It is used once in IDLE and once on release; a single shared instance fed from a muxed pointer is acceptable.

## Test plan
- **Single requester:** `numInputs`=4, `maxBurst`=4, port 2 valid with data 0x10..0x15, `outReady`=1.
  - `busy` goes high 1 cycle after valid.
  - Expected sequence: 4 words, then release, re-grant to port 2 with no bubble, then 2 words.
  - Final `xferCount` = 6.
- **Fairness:** all 4 ports continuously valid.
  - `grantId` sequence is 0,1,2,3,0, each holding exactly 4 transfers.
  - No port receives two consecutive grants.
- **Back-pressure:** port 1 is granted and `outReady` is toggled 1,0,0,1.
  - Grant is held; `burstCnt` advances only on the two ready cycles.
  - `inReady[1]` follows `outReady`; all other `inReady` bits stay 0.
- **Early drop:** port 0 is granted and drops `inValid` after 2 words while port 3 is valid.
  - Next cycle `grantId` = 3 with no IDLE cycle.
  - `rrPtr` is 1, so port 3 wins because ports 1–2 are idle.
- **maxBurst = 1:** ports 0 and 1 are valid.
  - Grants alternate 0,1,0,1 with one transfer each.
- **Mid-burst reset:** assert reset during port 2's 2nd transfer.
  - No handshake occurs in the reset cycle.
  - Afterwards `busy`=0, `xferCount`=0, `grantId`=0.
  - First grant after reset goes to the lowest valid port.
